// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the PE-row LSU request interface: round-robin
// arbitration of per-row four-phase req/ack handshakes into one word memory.
module lsu_mem_responder #(
  parameter int ROWS  = 4,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 ld_we,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DW-1:0]        ld_data,
  input  logic [ROWS-1:0]      r_req,
  input  logic [ROWS-1:0]      w_req,
  input  logic [ROWS*AW-1:0]   addr_bus,
  input  logic [ROWS*DW-1:0]   wdata_bus,
  output logic [ROWS-1:0]      resp_ack,
  output logic [ROWS*DW-1:0]   resp_data,
  output logic [ROWS-1:0]      req_err,
  output logic                 busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, PEND, SERVED} state_t;

  state_t            state [ROWS];
  logic [ROWS-1:0]   is_wr;
  logic [ROWS-1:0]   pend;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt_row;
  logic [PW-1:0]     cand;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [DW-1:0]     gnt_wdata;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     mem [DEPTH];

  always_comb begin
    pend     = '0;
    resp_ack = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      pend[i]     = (state[i] == PEND);
      resp_ack[i] = (state[i] == SERVED);
    end
  end

  assign busy = |(pend | resp_ack);

  // First PEND row found walking upward from the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_row = '0;
    cand    = '0;
    if (!init) begin
      for (int unsigned k = 0; k < ROWS; k++) begin
        cand = PW'((32'(ptr) + k) % 32'(ROWS));
        if (!gnt_vld && pend[cand]) begin
          gnt_vld = 1'b1;
          gnt_row = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_idx   = '0;
    gnt_wdata = '0;
    for (int unsigned j = 0; j < ROWS; j++) begin
      if (gnt_row == PW'(j)) begin
        gnt_idx   = addr_bus[j*AW +: IW];
        gnt_wdata = wdata_bus[j*DW +: DW];
      end
    end
  end

  assign rd_word = mem[gnt_idx];

  // Preload and granted writes never collide: no grant is issued while init is high.
  always_ff @(posedge clk) begin
    if (init) begin
      if (ld_we) mem[ld_addr[IW-1:0]] <= ld_data;
    end else if (gnt_vld && is_wr[gnt_row] && !rst) begin
      mem[gnt_idx] <= gnt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) state[i] <= IDLE;
      is_wr     <= '0;
      req_err   <= '0;
      resp_data <= '0;
      ptr       <= '0;
    end else begin
      if (gnt_vld) ptr <= (gnt_row == PW'(ROWS - 1)) ? '0 : gnt_row + PW'(1);
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (r_req[i] && w_req[i]) req_err[i] <= 1'b1;
        case (state[i])
          IDLE: begin
            if (r_req[i] || w_req[i]) begin
              state[i] <= PEND;
              is_wr[i] <= w_req[i];
            end
          end
          PEND: begin
            if (gnt_vld && gnt_row == PW'(i)) begin
              state[i]              <= SERVED;
              resp_data[i*DW +: DW] <= is_wr[i] ? '0 : rd_word;
            end
          end
          SERVED: begin
            if (!r_req[i] && !w_req[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: handshake latency, arbitration order,
// preload/init stall, conflicts, address wrap and mid-operation reset.
module tb_lsu_mem_responder;

  localparam int ROWS = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;

  logic                 clk;
  logic                 rst;
  logic                 init;
  logic                 ld_we;
  logic [AW-1:0]        ld_addr;
  logic [DW-1:0]        ld_data;
  logic [ROWS-1:0]      r_req;
  logic [ROWS-1:0]      w_req;
  logic [ROWS*AW-1:0]   addr_bus;
  logic [ROWS*DW-1:0]   wdata_bus;
  logic [ROWS-1:0]      resp_ack;
  logic [ROWS*DW-1:0]   resp_data;
  logic [ROWS-1:0]      req_err;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_responder #(.ROWS(ROWS), .AW(AW), .DW(DW), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .init(init), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .r_req(r_req), .w_req(w_req), .addr_bus(addr_bus),
    .wdata_bus(wdata_bus), .resp_ack(resp_ack), .resp_data(resp_data),
    .req_err(req_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_row(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_bus[r*AW +: AW]  = a;
    wdata_bus[r*DW +: DW] = d;
  endtask

  function automatic logic [31:0] rd(input int r);
    return resp_data[r*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1; init = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    r_req = '0; w_req = '0; addr_bus = '0; wdata_bus = '0;
    step(); step();
    chk("rst_ack",  32'(resp_ack), 32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    chk("rst_err",  32'(req_err),  32'h0);
    chk("rst_data0", rd(0),        32'h0);
    rst = 1'b0;

    // Init stall: rows 0,1 request while preloading; served 0 then 1 after init falls.
    init = 1'b1; ld_we = 1'b1; ld_addr = 16'd5; ld_data = 32'hDEADBEEF;
    set_row(0, 16'd5, 32'h0); set_row(1, 16'd9, 32'h0);
    r_req = 4'b0011;
    step();
    ld_addr = 16'd9; ld_data = 32'h00000011;
    step();
    ld_we = 1'b0;
    step();
    chk("init_ack",  32'(resp_ack), 32'h0);
    chk("init_busy", 32'(busy),     32'h1);
    init = 1'b0;
    step();
    chk("init_ack0",  32'(resp_ack), 32'b0001);
    chk("init_data0", rd(0),         32'hDEADBEEF);
    step();
    chk("init_ack1",  32'(resp_ack), 32'b0011);
    chk("init_data1", rd(1),         32'h00000011);
    r_req = 4'b0000;
    step();
    chk("init_drop_ack",  32'(resp_ack), 32'h0);
    chk("init_drop_busy", 32'(busy),     32'h0);

    // Single read latency (pointer now 2).
    r_req = 4'b0001;
    step();
    chk("lat_pend_ack",  32'(resp_ack), 32'h0);
    chk("lat_pend_busy", 32'(busy),     32'h1);
    step();
    chk("lat_ack",  32'(resp_ack), 32'b0001);
    chk("lat_data", rd(0),          32'hDEADBEEF);
    step();
    chk("lat_hold", 32'(resp_ack), 32'b0001);
    r_req = 4'b0000;
    step();
    chk("lat_fall", 32'(resp_ack), 32'h0);
    chk("lat_data_held", rd(0),    32'hDEADBEEF);

    // Row 2 write then readback, including an aliased address.
    set_row(2, 16'h03FF, 32'h12345678);
    w_req = 4'b0100;
    step(); step();
    chk("wr_ack",  32'(resp_ack), 32'b0100);
    chk("wr_data", rd(2),          32'h0);
    w_req = 4'b0000;
    step();
    r_req = 4'b0100;
    step(); step();
    chk("rb_ack",  32'(resp_ack), 32'b0100);
    chk("rb_data", rd(2),          32'h12345678);
    r_req = 4'b0000;
    step();
    set_row(2, 16'h07FF, 32'h0);
    r_req = 4'b0100;
    step(); step();
    chk("wrap_data", rd(2), 32'h12345678);
    r_req = 4'b0000;
    step();

    // Row 3 conflicting request: treated as write, sticky error.
    set_row(3, 16'd7, 32'hA5A5A5A5);
    r_req = 4'b1000; w_req = 4'b1000;
    step(); step();
    chk("cf_ack",  32'(resp_ack), 32'b1000);
    chk("cf_err",  32'(req_err),  32'b1000);
    chk("cf_data", rd(3),          32'h0);
    r_req = 4'b0000; w_req = 4'b0000;
    step();
    chk("cf_sticky", 32'(req_err), 32'b1000);

    // Contention from pointer 0; rows 0,1 drop and re-request mid-round.
    set_row(0, 16'd5, 32'h0); set_row(1, 16'h03FF, 32'h0);
    set_row(2, 16'd7, 32'h0); set_row(3, 16'h0405, 32'h0);
    r_req = 4'b1111;
    step();
    chk("ct_pend", 32'(resp_ack), 32'h0);
    step();
    chk("ct_g0",   32'(resp_ack), 32'b0001);
    chk("ct_d0",   rd(0),          32'hDEADBEEF);
    step();
    chk("ct_g1",   32'(resp_ack), 32'b0011);
    chk("ct_d1",   rd(1),          32'h12345678);
    r_req = 4'b1100;
    step();
    chk("ct_g2",   32'(resp_ack), 32'b0100);
    chk("ct_d2",   rd(2),          32'hA5A5A5A5);
    set_row(1, 16'd7, 32'h0);
    r_req = 4'b1111;
    step();
    chk("ct_g3",   32'(resp_ack), 32'b1100);
    chk("ct_d3",   rd(3),          32'hDEADBEEF);
    step();
    chk("ct_r2g0", 32'(resp_ack), 32'b1101);
    step();
    chk("ct_r2g1", 32'(resp_ack), 32'b1111);
    chk("ct_r2d1", rd(1),          32'hA5A5A5A5);
    r_req = 4'b0000;
    step();
    chk("ct_idle", 32'(busy), 32'h0);

    // Pointer at 2: rows 0 and 3 together -> row 3 first.
    r_req = 4'b1001;
    step(); step();
    chk("rr_first",  32'(resp_ack), 32'b1000);
    step();
    chk("rr_second", 32'(resp_ack), 32'b1001);
    r_req = 4'b0000;
    step();

    // Reset lands on the cycle row 1's write would be granted.
    set_row(1, 16'd9, 32'hFFFF0000);
    w_req = 4'b0010;
    step();
    chk("mr_pend", 32'(busy), 32'h1);
    rst = 1'b1;
    step();
    chk("mr_ack",  32'(resp_ack), 32'h0);
    chk("mr_busy", 32'(busy),     32'h0);
    chk("mr_err",  32'(req_err),  32'h0);
    rst = 1'b0; w_req = 4'b0000;
    step();
    set_row(0, 16'd9, 32'h0); set_row(2, 16'd5, 32'h0);
    r_req = 4'b0101;
    step(); step();
    chk("mr_ptr0",  32'(resp_ack), 32'b0001);
    chk("mr_mem9",  rd(0),          32'h00000011);
    step();
    chk("mr_next",  32'(resp_ack), 32'b0101);
    chk("mr_d2",    rd(2),          32'hDEADBEEF);
    r_req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
